// File: rtl/keys_edge_pio_if.sv
// Avalon-MM slave bundle for keys_edge_pio: word-addressed register access plus level irq.
// No wait states, so there are no handshake signals beyond the strobes.
interface keys_edge_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );
endinterface

// File: rtl/keys_edge_pio.sv
// Edge-capturing input PIO with masked irq; 2-flop sync, DATA +2 edges, capture/irq +3 edges; no wait states.
// Define KEYS_EDGE_PIO_DEBOUNCE_EN to insert a per-bit debounce counter (adds DEBOUNCE_CYCLES of latency).
module keys_edge_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    keys_edge_pio_if.slave   bus,
    input  logic [WIDTH-1:0] in_port
);

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, cond;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] rise, fall, edge_sel, edge_det, clr_mask;
    logic [1:0]       arm_q, arm_d;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rdata;

    assign wr_en = bus.chipselect & ~bus.write_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= cond;
        end
    end

`ifdef KEYS_EDGE_PIO_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]       cond_q, cond_d;
    logic [WIDTH-1:0][15:0] db_cnt_q, db_cnt_d;

    // A bit only follows sync2 once it has disagreed with cond for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        cond_d   = cond_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == cond_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                cond_d[i]   = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            cond_q   <= cond_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign cond = cond_q;
`else
    assign cond = sync2_q;
`endif

    assign rise = cond & ~prev_q;
    assign fall = ~cond & prev_q;

    if (EDGE_TYPE == 0) begin : g_rise
        assign edge_sel = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_sel = fall;
    end else begin : g_any
        assign edge_sel = rise | fall;
    end

    // Edges are ignored until the reset-zeroed pipeline has filled with the real input level.
    assign armed    = (arm_q == 2'd3);
    assign arm_d    = armed ? arm_q : arm_q + 2'd1;
    assign edge_det = armed ? edge_sel : '0;

    assign clr_mask  = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    assign edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
    assign irqmask_d = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : irqmask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_q     <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            arm_q     <= arm_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            2'd0:    rdata[WIDTH-1:0] = cond;
            2'd2:    rdata[WIDTH-1:0] = irqmask_q;
            2'd3:    rdata[WIDTH-1:0] = edgecap_q;
            default: rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign bus.irq      = |(edgecap_q & irqmask_q);

    if (WIDTH < 32) begin : g_wd_unused
        logic unused_wdata;
        assign unused_wdata = ^bus.writedata[31:WIDTH];
    end

endmodule

// File: doc/keys_edge_pio.md
Name: keys_edge_pio

Overview:
- Avalon-MM slave input PIO: the inbound counterpart to the LED output PIO.
- Samples asynchronous push-button/switch inputs and synchronises them.
- Detects per-bit edges into a sticky edge-capture register, under a per-bit interrupt mask.
- Raises an irq to the Nios II so game input (jump/attack/move keys) is interrupt-driven instead of polled.

Parameters:
WIDTH, 4, number of input bits (in_port width, register width)
EDGE_TYPE, 1, 0 = rising, 1 = falling, 2 = any edge (buttons are active-low, so falling is the default)
DEBOUNCE_CYCLES, 16, stable-cycle count; used only when the optional feature is compiled in (range 2..65535)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  2  register word select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, combinational from address; bits 31:WIDTH read 0
in_port  input  WIDTH  raw asynchronous inputs
irq  output  1  interrupt request, level, active-high

Interface (already decided): one clock, clk; reset is asynchronous and active-high, port reset. Every flop clears on reset assertion, with no clk edge required.

Behaviour:
- Register map (word addresses):
  - 0 DATA: read = conditioned input value; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQMASK: read/write; bits WIDTH-1:0.
  - 3 EDGECAPTURE: read; write-1-to-clear per bit.
- Write occurs on a clk edge with chipselect=1 and write_n=0. No wait states. Reads have no side effects.
- Input path:
  - in_port -> sync1 -> sync2 (2-flop synchroniser per bit) -> cond (conditioned value).
  - Without debounce, cond = sync2.
  - prev registers cond every cycle.
- Edge detect (per bit, combinational, ANDed with armed):
  - rise = cond & ~prev
  - fall = ~cond & prev
  - EDGE_TYPE selects rise, fall, or rise|fall.
- Arming:
  - A 2-bit counter starts at 0 on reset and counts 3 clk edges after reset deasserts; armed is 1 from then on.
  - Purpose: prevents spurious edges while the reset-zeroed sync/prev flops fill with the real input level.
  - Reset mid-operation re-zeroes all state, including the counter.
- Edge capture:
  - Set: edgecapture[i] <= 1 on a detected edge.
  - Clear: edgecapture[i] <= 0 on a write to address 3 with writedata[i]=1.
  - Simultaneous detected edge and clear on the same bit in the same cycle: set wins; the bit stays 1.
  - Bits are sticky; multiple edges before a clear collapse to a single 1.
- irq = |(edgecapture & irqmask), combinational from registers.
  - Unmasking a bit whose edgecapture is already set raises irq the cycle after the write.
- Latency: in_port changes before clk edge N.
  - DATA reflects the change after edge N+1.
  - edgecapture bit and irq set after edge N+2.
- Reset values:
  - readdata follows the register contents combinationally, so it reads 0 for all addresses out of reset.
  - irq = 0; sync1, sync2, prev, irqmask, edgecapture, armed counter = 0.

Optional Feature:
- Macro: KEYS_EDGE_PIO_DEBOUNCE_EN.
- Defined:
  - Each bit gets a 16-bit counter between sync2 and cond.
  - Counter resets to 0 whenever sync2 == cond.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, cond <= sync2 and the counter clears.
  - Input-to-DATA latency grows by DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach cond and produce no edge.
  - cond and counters reset to 0.
- Undefined: no counters; cond = sync2; DEBOUNCE_CYCLES ignored.

Test Plan:
- Reset release with in_port=4'hF (EDGE_TYPE=2) -> DATA reads 0xF after edge 2; EDGECAPTURE reads 0 and irq stays 0 (armed suppresses the fill-in edge).
- EDGE_TYPE=1, IRQMASK=0x1, in_port 4'hF->4'hE -> EDGECAPTURE=0x1 and irq=1 two edges after the change; write 0x1 to address 3 -> EDGECAPTURE=0, irq=0 next cycle.
- IRQMASK=0, falling edge on bit 2 -> EDGECAPTURE=0x4 with irq=0; then write IRQMASK=0x4 -> irq=1 the cycle after the write.
- Falling edge on bit 1 detected in the same cycle as a clear write of 0x2 -> EDGECAPTURE bit 1 remains 1.
- Assert reset while EDGECAPTURE=0x5 and IRQMASK=0xF -> irq drops immediately with no clk edge; all registers read 0 after release.
- With KEYS_EDGE_PIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 5-cycle low pulse on bit 0 -> no capture, DATA unchanged; a 40-cycle low pulse -> EDGECAPTURE bit 0 set 2+16 cycles after the falling edge.
